// File: rtl/relu_backprop_neuron.sv
// relu_backprop_neuron: streams N (w, delta) Q16.16 pairs, sums the products with
// wrap-around, then gates the sum with the forward-pass ReLU derivative.
// Latency: out_valid rises in the second cycle after the last accepted beat.
// Backpressure: in_ready depends on state only; grad is held in DONE until out_ready.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, d           begin a gradient (IDLE only), ReLU derivative latched with start
//   in_valid/in_ready  w/delta beat handshake (accepted when both high on an edge)
//   w, delta           signed Q16.16 weight and downstream gradient
//   out_valid/out_ready result handshake; grad is 0 whenever out_valid is low
//   busy               high in every state except IDLE
module relu_backprop_neuron #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        d,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] w,
    input  logic [31:0] delta,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] grad,
    output logic        busy
);

    // One extra count value so the counter can reach N without wrapping.
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_d_lat;
    logic [CNT_W-1:0]      r_cnt;
    logic signed [31:0]    r_prod;
    logic                  r_prod_v;
    logic signed [31:0]    r_acc;

    logic                  w_beat;
    logic                  w_start_acc;
    logic signed [47:0]    w_w48;
    logic signed [47:0]    w_d48;
    logic signed [47:0]    w_full;
    logic signed [31:0]    w_prod;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign w_beat      = (r_state == S_ACCUM) && in_valid;
    assign w_start_acc = (r_state == S_IDLE) && start;

    // ------------------------------------------------------------------
    // Q16.16 product. Only bits [47:16] of the full 64-bit product are kept,
    // and the low 48 bits of a signed product do not depend on the upper
    // operand bits beyond sign extension, so a 48-bit multiply suffices.
    // The arithmetic shift discards the fraction, i.e. rounds toward -inf.
    // ------------------------------------------------------------------
    assign w_w48  = {{16{w[31]}}, w};
    assign w_d48  = {{16{delta[31]}}, delta};
    assign w_full = w_w48 * w_d48;
    assign w_prod = 32'(w_full >>> 16);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_beat && (r_cnt == LAST_BEAT)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Single cycle: the last registered product lands in acc here.
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Product register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= '0;
            r_prod_v <= 1'b0;
        end else begin
            r_prod_v <= w_beat;
            if (w_beat) begin
                r_prod <= w_prod;
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator, beat counter and derivative latch.
    // An accepted start clears acc; prod_v is always 0 in IDLE, so no
    // stale product can collide with the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_d_lat <= 1'b0;
        end else if (w_start_acc) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_d_lat <= d;
        end else begin
            if (r_prod_v) begin
                r_acc <= r_acc + r_prod;   // 32-bit wrap-around, no saturation
            end
            if (w_beat) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from state only
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign grad      = (out_valid && r_d_lat) ? r_acc : 32'd0;

endmodule

// File: tb/tb_relu_backprop_neuron.sv
module tb_relu_backprop_neuron;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        d;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] w;
    logic [31:0] delta;
    wire         in_ready;
    wire         out_valid;
    wire         busy;
    wire  [31:0] grad;

    int errors = 0;
    int checks = 0;

    logic [31:0] ws[N];
    logic [31:0] ds[N];

    always #5 clk = ~clk;

    relu_backprop_neuron #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w         (w),
        .delta     (delta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad      (grad),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: exact real-valued product floored to Q16.16, summed mod 2^32.
    function automatic logic [31:0] model(input logic dv);
        longint      p;
        longint      q;
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < N; i++) begin
            p = longint'($signed(ws[i])) * longint'($signed(ds[i]));
            q = p / 65536;
            if (p < 0 && (p % 65536) != 0) q = q - 1;
            s = s + q[31:0];
        end
        return dv ? s : 32'd0;
    endfunction

    task automatic load_basic;
        ws[0] = 32'h0001_0000; ws[1] = 32'h0002_0000;
        ws[2] = 32'hFFFF_8000; ws[3] = 32'h0000_4000;
        for (int i = 0; i < N; i++) ds[i] = 32'h0000_8000;
    endtask

    // Runs one gradient from IDLE up to the first cycle with out_valid high.
    // gap_pct: chance of an idle in_valid cycle in ACCUM; noise: in_valid
    // pulses with garbage data in IDLE and DRAIN.
    task automatic do_run(input logic dv, input int gap_pct, input bit noise,
                          output logic [31:0] g, output int beats,
                          output int lat_last, output int lat_start, output bit to);
        int idx;
        int cyc;
        bit v;
        beats = 0; lat_last = 0; lat_start = 0; cyc = 0; idx = 0; to = 0;
        if (noise) begin
            in_valid = 1'b1; w = $urandom; delta = $urandom;
            if (in_valid && in_ready) beats++;
            tick;
        end
        start = 1'b1; d = dv; in_valid = noise;
        if (in_valid && in_ready) beats++;
        tick;
        lat_start = 1;
        start = 1'b0; d = 1'($urandom_range(1));
        while (idx < N && cyc < 500) begin
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            w     = v ? ws[idx] : $urandom;
            delta = v ? ds[idx] : $urandom;
            if (in_valid && in_ready) begin
                idx++;
                beats++;
            end
            tick;
            lat_start++;
            cyc++;
        end
        in_valid = noise; w = $urandom; delta = $urandom;
        while (!out_valid && cyc < 500) begin
            if (in_valid && in_ready) beats++;
            tick;
            lat_last++;
            lat_start++;
            cyc++;
        end
        in_valid = 1'b0;
        to = !out_valid;
        g  = grad;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; d = 0; in_valid = 0; out_ready = 0; w = 0; delta = 0;
        tick; tick;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (grad !== 32'd0)     begin errors++; $display("FAIL reset_grad got=%h exp=0", grad); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [31:0] g; int beats, ll, ls; bit to;
        load_basic();
        do_run(1'b1, 0, 1'b0, g, beats, ll, ls, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", to); end
        checks++; if (g !== 32'h0001_6000) begin errors++; $display("FAIL basic_grad got=%h exp=00016000", g); end
        checks++; if (g !== model(1'b1)) begin errors++; $display("FAIL basic_model got=%h exp=%h", g, model(1'b1)); end
        checks++; if (beats !== N) begin errors++; $display("FAIL basic_beats got=%0d exp=%0d", beats, N); end
        checks++; if (ll !== 1) begin errors++; $display("FAIL basic_latency got=%0d exp=1", ll); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
        handshake();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
        checks++; if (grad !== 32'd0) begin errors++; $display("FAIL basic_grad_idle got=%h exp=0", grad); end
    endtask

    task automatic test_d0;
        logic [31:0] g; int beats, ll, ls; bit to;
        load_basic();
        do_run(1'b0, 0, 1'b0, g, beats, ll, ls, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL d0_timeout got=%b exp=0", to); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL d0_out_valid got=%b exp=1", out_valid); end
        checks++; if (g !== 32'd0) begin errors++; $display("FAIL d0_grad got=%h exp=0", g); end
        checks++; if (beats !== N) begin errors++; $display("FAIL d0_beats got=%0d exp=%0d", beats, N); end
        handshake();
    endtask

    task automatic test_wrap_floor;
        logic [31:0] g; int beats, ll, ls; bit to;
        ws[0] = 32'h7FFF_0000; ws[1] = 32'h7FFF_0000; ws[2] = 32'h0; ws[3] = 32'h0;
        ds[0] = 32'h0001_0000; ds[1] = 32'h0001_0000; ds[2] = 32'h1234_5678; ds[3] = 32'h0;
        do_run(1'b1, 0, 1'b0, g, beats, ll, ls, to);
        checks++; if (g !== 32'hFFFE_0000) begin errors++; $display("FAIL wrap_grad got=%h exp=fffe0000", g); end
        handshake();
        ws[0] = 32'hFFFF_FFFF; ds[0] = 32'h0000_8000;
        ws[1] = 32'h0; ws[2] = 32'h0; ws[3] = 32'h0;
        do_run(1'b1, 0, 1'b0, g, beats, ll, ls, to);
        checks++; if (g !== 32'hFFFF_FFFF) begin errors++; $display("FAIL floor_grad got=%h exp=ffffffff", g); end
        handshake();
    endtask

    task automatic test_random_gaps;
        logic [31:0] g1, g2; int beats, ll, ls; bit to; logic dv;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                ws[i] = $urandom;
                ds[i] = (it < 3) ? $urandom : 32'($signed($urandom_range(262143)) - 131072);
            end
            dv = (it == 2) ? 1'b0 : 1'b1;
            do_run(dv, 40, 1'b1, g1, beats, ll, ls, to);
            checks++; if (g1 !== model(dv)) begin errors++; $display("FAIL rand_grad it=%0d got=%h exp=%h", it, g1, model(dv)); end
            checks++; if (beats !== N) begin errors++; $display("FAIL rand_beats it=%0d got=%0d exp=%0d", it, beats, N); end
            in_valid = 1'b1;   // pulse in DONE must not be consumed
            tick;
            in_valid = 1'b0;
            handshake();
            do_run(dv, 0, 1'b0, g2, beats, ll, ls, to);
            checks++; if (g2 !== g1) begin errors++; $display("FAIL rand_gapfree it=%0d got=%h exp=%h", it, g2, g1); end
            handshake();
        end
    endtask

    task automatic test_hold;
        logic [31:0] g; int beats, ll, ls; bit to;
        load_basic();
        do_run(1'b1, 0, 1'b0, g, beats, ll, ls, to);
        for (int c = 0; c < 5; c++) begin
            start = c[0]; d = 1'b0; in_valid = 1'b1;
            tick;
            checks++; if (grad !== 32'h0001_6000) begin errors++; $display("FAIL hold_grad c=%0d got=%h exp=00016000", c, grad); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid c=%0d got=%b exp=1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready c=%0d got=%b exp=0", c, in_ready); end
        end
        start = 1'b0; in_valid = 1'b0;
        handshake();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy got=%b exp=0", busy); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_queued_start got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset;
        logic [31:0] g; int beats, ll, ls; bit to;
        load_basic();
        start = 1'b1; d = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b1; w = ws[0]; delta = ds[0];
        tick;
        w = ws[1]; delta = ds[1];
        tick;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
        checks++; if (grad !== 32'd0)    begin errors++; $display("FAIL areset_grad got=%h exp=0", grad); end
        tick;
        rst = 1'b0;
        tick;
        do_run(1'b1, 0, 1'b0, g, beats, ll, ls, to);
        checks++; if (g !== 32'h0001_6000) begin errors++; $display("FAIL areset_rerun got=%h exp=00016000", g); end
        handshake();
    endtask

    task automatic test_back_to_back;
        logic [31:0] g; int beats, ll, ls; bit to;
        load_basic();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            do_run(1'b1, 0, 1'b0, g, beats, ll, ls, to);
            checks++; if (ls !== N + 2) begin errors++; $display("FAIL b2b_start_latency r=%0d got=%0d exp=%0d", r, ls, N + 2); end
            checks++; if (g !== 32'h0001_6000) begin errors++; $display("FAIL b2b_grad r=%0d got=%h exp=00016000", r, g); end
            tick;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle r=%0d got=%b exp=0", r, busy); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_d0();
        test_wrap_floor();
        test_random_gaps();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
